// File: rtl/rr_decode_arbiter8.sv
`default_nettype none
// ============================================================================
// rr_decode_arbiter8 : 8-way round-robin arbiter, one-hot + binary grant out
// Rev 1.0
// ============================================================================
module rr_decode_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_sel,
    output logic       gnt_valid
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit               c_hold_en    = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] c_hold_limit = CNT_W'(MAX_HOLD);

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
    logic [7:0]       r_gnt, w_gnt_nxt;
    logic [2:0]       r_sel, w_sel_nxt;
    logic             r_valid, w_valid_nxt;

    logic [15:0]      w_dbl;
    logic [7:0]       w_rot;
    logic [2:0]       w_off;
    logic [2:0]       w_idx;

    // Rotate so bit j corresponds to client (ptr + j) mod 8; lowest set bit wins.
    assign w_dbl = {req, req} >> r_ptr;
    assign w_rot = w_dbl[7:0];

    always_comb begin
        w_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 3'(i);
            end
        end
    end

    assign w_idx = r_ptr + w_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= 3'd0;
            r_hold_cnt <= '0;
            r_gnt      <= 8'h00;
            r_sel      <= 3'd0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gnt      <= w_gnt_nxt;
            r_sel      <= w_sel_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        case (r_state)
            IDLE: begin
                if (req != 8'h00) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_idx;
                    w_gnt_nxt   = 8'h01 << w_idx;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = CNT_W'(1);
                end
            end
            GRANT: begin
                // Dropped request and hold-limit expiry both release the same way.
                if (!req[r_sel] || (c_hold_en && (r_hold_cnt == c_hold_limit))) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = r_sel + 3'd1;
                    w_gnt_nxt   = 8'h00;
                    w_sel_nxt   = 3'd0;
                    w_valid_nxt = 1'b0;
                end else if (r_hold_cnt != '1) begin
                    w_hold_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_sel   = r_sel;
    assign gnt_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_decode_arbiter8.sv
`default_nettype none
// ============================================================================
// tb_rr_decode_arbiter8 : vector table + scoreboard bench for rr_decode_arbiter8
// Rev 1.0
// ============================================================================
module tb_rr_decode_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_d, req_h4, req_h2, req_h0;
    logic [7:0] gnt_d, gnt_h4, gnt_h2, gnt_h0;
    logic [2:0] sel_d, sel_h4, sel_h2, sel_h0;
    logic       val_d, val_h4, val_h2, val_h0;

    always #5 clk = ~clk;

    rr_decode_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) dut_d (
        .clk(clk), .rst_n(rst_n), .req(req_d),
        .gnt(gnt_d), .gnt_sel(sel_d), .gnt_valid(val_d));
    rr_decode_arbiter8 #(.MAX_HOLD(4), .CNT_W(3)) dut_h4 (
        .clk(clk), .rst_n(rst_n), .req(req_h4),
        .gnt(gnt_h4), .gnt_sel(sel_h4), .gnt_valid(val_h4));
    rr_decode_arbiter8 #(.MAX_HOLD(2), .CNT_W(2)) dut_h2 (
        .clk(clk), .rst_n(rst_n), .req(req_h2),
        .gnt(gnt_h2), .gnt_sel(sel_h2), .gnt_valid(val_h2));
    rr_decode_arbiter8 #(.MAX_HOLD(0), .CNT_W(1)) dut_h0 (
        .clk(clk), .rst_n(rst_n), .req(req_h0),
        .gnt(gnt_h0), .gnt_sel(sel_h0), .gnt_valid(val_h0));

    typedef struct {
        int unsigned dut;
        logic [7:0]  req;
        logic [7:0]  gnt;
        logic [2:0]  sel;
        logic        valid;
    } vec_t;

    typedef struct {
        int unsigned dut;
        logic [7:0]  gnt;
        logic [2:0]  sel;
        logic        valid;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input int unsigned d, input logic [7:0] r,
                                input logic [7:0] g, input logic [2:0] s,
                                input logic v);
        vec_t t;
        t.dut = d; t.req = r; t.gnt = g; t.sel = s; t.valid = v;
        vecs.push_back(t);
    endfunction

    task automatic drive_req(input int unsigned d, input logic [7:0] r);
        case (d)
            0:       req_d  = r;
            1:       req_h4 = r;
            2:       req_h2 = r;
            default: req_h0 = r;
        endcase
    endtask

    task automatic check(input string name, input exp_t e);
        logic [7:0] g;
        logic [2:0] s;
        logic       v;
        case (e.dut)
            0:       begin g = gnt_d;  s = sel_d;  v = val_d;  end
            1:       begin g = gnt_h4; s = sel_h4; v = val_h4; end
            2:       begin g = gnt_h2; s = sel_h2; v = val_h2; end
            default: begin g = gnt_h0; s = sel_h0; v = val_h0; end
        endcase
        n_tests++;
        if (g !== e.gnt || s !== e.sel || v !== e.valid) begin
            n_fail++;
            $display("FAIL %s: got gnt=%h sel=%0d valid=%b, want gnt=%h sel=%0d valid=%b",
                     name, g, s, v, e.gnt, e.sel, e.valid);
        end
    endtask

    // Drive one request pattern, expect the given registered outputs after the edge.
    task automatic step(input string name, input int unsigned d, input logic [7:0] r,
                        input logic [7:0] g, input logic [2:0] s, input logic v);
        exp_t e;
        drive_req(d, r);
        e.dut = d; e.gnt = g; e.sel = s; e.valid = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, want one entry", name);
        end else begin
            check(name, sb.pop_front());
        end
    endtask

    task automatic check_zero(input string name, input int unsigned d);
        exp_t e;
        e.dut = d; e.gnt = 8'h00; e.sel = 3'd0; e.valid = 1'b0;
        check(name, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[3];
        order[0] = 2; order[1] = 3; order[2] = 5;

        // Default instance: first grant after reset, short request, ptr continuation.
        add(0, 8'hFF, 8'h01, 3'd0, 1'b1);
        add(0, 8'h00, 8'h00, 3'd0, 1'b0);
        add(0, 8'h00, 8'h00, 3'd0, 1'b0);
        add(0, 8'h20, 8'h20, 3'd5, 1'b1);
        add(0, 8'h20, 8'h20, 3'd5, 1'b1);
        add(0, 8'h20, 8'h20, 3'd5, 1'b1);
        add(0, 8'h00, 8'h00, 3'd0, 1'b0);
        add(0, 8'h41, 8'h40, 3'd6, 1'b1);
        add(0, 8'h00, 8'h00, 3'd0, 1'b0);
        add(0, 8'h81, 8'h80, 3'd7, 1'b1);
        add(0, 8'h01, 8'h00, 3'd0, 1'b0);
        add(0, 8'h01, 8'h01, 3'd0, 1'b1);
        add(0, 8'h00, 8'h00, 3'd0, 1'b0);

        // Hold limit 4 with clients 0 and 7 both requesting.
        for (int k = 0; k < 4; k++) add(1, 8'h81, 8'h01, 3'd0, 1'b1);
        add(1, 8'h81, 8'h00, 3'd0, 1'b0);
        for (int k = 0; k < 4; k++) add(1, 8'h81, 8'h80, 3'd7, 1'b1);
        add(1, 8'h81, 8'h00, 3'd0, 1'b0);
        add(1, 8'h81, 8'h01, 3'd0, 1'b1);
        add(1, 8'hFF, 8'h01, 3'd0, 1'b1);
        add(1, 8'h00, 8'h00, 3'd0, 1'b0);

        // Hold limit 2, rotation over clients 2, 3, 5.
        for (int rep = 0; rep < 2; rep++) begin
            for (int c = 0; c < 3; c++) begin
                add(2, 8'h2C, 8'(1 << order[c]), 3'(order[c]), 1'b1);
                add(2, 8'h2C, 8'(1 << order[c]), 3'(order[c]), 1'b1);
                add(2, 8'h2C, 8'h00, 3'd0, 1'b0);
            end
        end
        add(2, 8'h00, 8'h00, 3'd0, 1'b0);

        rst_n  = 1'b0;
        req_d  = 8'hFF;
        req_h4 = 8'h00;
        req_h2 = 8'h00;
        req_h0 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_d", 0);
        check_zero("reset_h4", 1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d_dut%0d", i, vecs[i].dut), vecs[i].dut,
                 vecs[i].req, vecs[i].gnt, vecs[i].sel, vecs[i].valid);
        end

        // Unlimited hold: client 0 keeps the grant while client 1 waits.
        for (int k = 0; k < 100; k++) begin
            step($sformatf("unlim_hold%0d", k), 3, 8'h03, 8'h01, 3'd0, 1'b1);
        end
        step("unlim_drop", 3, 8'h02, 8'h00, 3'd0, 1'b0);
        step("unlim_next", 3, 8'h02, 8'h02, 3'd1, 1'b1);
        step("unlim_end", 3, 8'h00, 8'h00, 3'd0, 1'b0);

        // Asynchronous reset while client 6 holds the grant.
        step("ar_grant6", 0, 8'h40, 8'h40, 3'd6, 1'b1);
        step("ar_hold6", 0, 8'h40, 8'h40, 3'd6, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("ar_async_drop", 0);
        #1;
        rst_n = 1'b1;
        step("ar_restart_ptr0", 0, 8'h41, 8'h01, 3'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_decode_arbiter8.md
Name: rr_decode_arbiter8

Overview:
- Eight-requester round-robin arbiter for one shared resource.
- Issues each grant both as a 3-bit binary select and as its one-hot decode (8 bits), so downstream logic gets the same code both ways.
- Sits between eight client request lines and the shared datapath.
- Registered outputs.
- Optional hold limit stops one client from monopolising the resource.

Parameters:
- MAX_HOLD, 16: max consecutive grant cycles per tenure. 0 = unlimited (hold until req drops).
- CNT_W, 5: hold counter width. Must satisfy 2^CNT_W > MAX_HOLD; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request lines, bit i = client i. Level-sensitive.
- gnt  output  8  one-hot grant. 8'h00 when no grant.
- gnt_sel  output  3  binary index of the granted client. 3'd0 when no grant.
- gnt_valid  output  1  high while a grant is active.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset rst_n is asynchronous, active-low.
  - Reset forces immediately, with no clock needed: gnt=0, gnt_sel=0, gnt_valid=0, state=IDLE, ptr=0, hold_cnt=0.
- Internal state:
  - ptr (3 bit): highest-priority index for the next arbitration.
  - hold_cnt (CNT_W bit).
  - state: IDLE or GRANT.
- IDLE:
  - If req==0: stay in IDLE, outputs remain 0.
  - Otherwise select idx = first set bit of req, scanning ptr, ptr+1, ... with wrap modulo 8.
  - Next edge: state=GRANT, gnt_sel=idx, gnt=1<<idx, gnt_valid=1, hold_cnt=1.
  - Latency: grant visible exactly 1 cycle after req is sampled in IDLE.
- GRANT, evaluated each edge in this priority order:
  1. req[gnt_sel]==0: release.
  2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD: forced release, even if req is still high.
  3. Otherwise hold; hold_cnt increments, saturating at all-ones.
- Release (either kind):
  - Next edge: gnt=0, gnt_sel=0, gnt_valid=0, state=IDLE.
  - ptr = (gnt_sel+1) mod 8, so 7 wraps to 0.
- Grant spacing:
  - At least one idle cycle always separates consecutive grants.
  - Grants never switch directly from one client to another.
- Forced-released client:
  - It stays eligible if its req is still high.
  - It now has the lowest priority because of the ptr advance.
- Invariants:
  - gnt_valid=1 implies gnt == one-hot(gnt_sel) and exactly one bit set.
  - gnt_valid=0 implies gnt=0 and gnt_sel=0.
- Input timing:
  - Requests of non-granted clients do not affect outputs during GRANT.
  - Requests are sampled only in IDLE.
  - A req pulse shorter than one cycle that misses the edge is ignored (no latching).
- Reset mid-grant: outputs drop asynchronously. After release, arbitration restarts from ptr=0.
- Worst-case wait for a held request, with MAX_HOLD!=0: 7*(MAX_HOLD+1)+1 cycles.

Test Plan:
- Reset and first grant:
  - Stimulus: hold rst_n=0 with req=8'hFF, then release rst_n.
  - Required: outputs 0 during reset. One cycle after the first post-reset edge, gnt=8'h01, gnt_sel=0, gnt_valid=1.
- Single short request:
  - Stimulus: req=8'h20 for exactly 3 sampled cycles from IDLE.
  - Required: gnt=8'h20, gnt_sel=5 for 3 cycles, then all outputs 0 for 1 cycle. Next arbitration starts from ptr=6.
- Fairness with hold limit:
  - Stimulus: MAX_HOLD=4, req=8'h81 held constant.
  - Required: grant sequence client 0 (4 cycles), idle (1), client 7 (4), idle (1), client 0 ... Shows ptr wrap 7 to 0.
- Rotation order:
  - Stimulus: MAX_HOLD=2, req=8'h2C held.
  - Required: grant order 2,3,5,2,3,5, each 2 cycles, with 1 idle cycle between grants.
- Unlimited hold:
  - Stimulus: MAX_HOLD=0, req=8'h03 held 100 cycles.
  - Required: gnt=8'h01 the entire time. Dropping req[0] gives 1 idle cycle, then gnt=8'h02.
- Asynchronous reset mid-grant:
  - Stimulus: while client 6 is granted, pulse rst_n low between clock edges.
  - Required: gnt, gnt_sel and gnt_valid go 0 without waiting for a clock edge. With req=8'h41 after release, the next grant goes to client 0.
